// File: rtl/uart_rx_fifo_ctrl_if.sv
// Read-side bundle of the UART RX FIFO controller: pop/clear requests in, head entry, status and interrupts out.
// Ports: rden_i/ovr_clr_i (consumer -> FIFO); rd_data_o, rd_err_o, level_o, full_o, empty_o,
//        overrun_o, thresh_irq_o, timeout_irq_o (FIFO -> consumer). master = FIFO side, slave = consumer side.
interface uart_rx_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CW         = 5
);
  logic                  rden_i;
  logic                  ovr_clr_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic [2:0]            rd_err_o;
  logic [CW-1:0]         level_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  overrun_o;
  logic                  thresh_irq_o;
  logic                  timeout_irq_o;

  modport master (
    input  rden_i, ovr_clr_i,
    output rd_data_o, rd_err_o, level_o, full_o, empty_o, overrun_o, thresh_irq_o, timeout_irq_o
  );

  modport slave (
    output rden_i, ovr_clr_i,
    input  rd_data_o, rd_err_o, level_o, full_o, empty_o, overrun_o, thresh_irq_o, timeout_irq_o
  );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive path: 2-FF sync, oversampling framer (data/parity/1-2 stop), error-tagged FWFT FIFO, irqs.
// Latency: entry visible 2 clk after the mid-bit sample of the last stop bit; irqs registered.
// Backpressure: none on the line; a char arriving while full (no pop) is dropped and sets sticky overrun.
// Ports: clk_i/rstn_i, baud_tick_i (OVERSAMPLE per bit), rx_i (async serial), cfg_* (latched at start),
//        rd_if (master modport: pop/clear in; head data/err, level, full/empty, overrun, irqs out).
module uart_rx_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int OVERSAMPLE    = 16,
  parameter int TIMEOUT_CHARS = 4,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          baud_tick_i,
  input  logic          rx_i,
  input  logic          cfg_par_en_i,
  input  logic          cfg_par_odd_i,
  input  logic          cfg_stop2_i,
  input  logic [CW-1:0] cfg_thresh_i,
  uart_rx_fifo_ctrl_if.master rd_if
);

  localparam int PW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW       = $clog2(OVERSAMPLE);
  localparam int BW       = $clog2(DATA_WIDTH);
  localparam int EW       = DATA_WIDTH + 3;
  localparam int TO_TICKS = TIMEOUT_CHARS * 10 * OVERSAMPLE;
  localparam int TOW      = $clog2(TO_TICKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HI} state_t;

  // ---------------- synchroniser ----------------
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // ---------------- framer FSM ----------------
  state_t                state_q;
  logic [TW-1:0]         tick_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q, par_odd_q, stop2_q, par_err_q, par_bit_q;
  logic                  push_q;
  logic [EW-1:0]         push_ent_q;

  logic start_det, sample, brk_det;
  assign start_det = (state_q == S_IDLE) && rx_prev_q && !rx_s2_q;
  assign sample    = baud_tick_i && (tick_cnt_q == TW'(OVERSAMPLE / 2 - 1));
  // par_bit_q is cleared at start, so a frame without parity qualifies on data alone
  assign brk_det   = (shift_q == '0) && !par_bit_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      par_err_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      push_q     <= 1'b0;
      push_ent_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (baud_tick_i)
        tick_cnt_q <= (tick_cnt_q == TW'(OVERSAMPLE - 1)) ? '0 : tick_cnt_q + 1'b1;
      case (state_q)
        S_IDLE: if (start_det) begin
          tick_cnt_q <= '0;
          par_en_q   <= cfg_par_en_i;
          par_odd_q  <= cfg_par_odd_i;
          stop2_q    <= cfg_stop2_i;
          par_err_q  <= 1'b0;
          par_bit_q  <= 1'b0;
          state_q    <= S_START;
        end
        S_START: if (sample) begin
          bit_cnt_q <= '0;
          state_q   <= rx_s2_q ? S_IDLE : S_DATA;  // high at mid-bit: glitch, not a start bit
        end
        S_DATA: if (sample) begin
          shift_q   <= {rx_s2_q, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_WIDTH - 1))
            state_q <= par_en_q ? S_PARITY : S_STOP1;
        end
        S_PARITY: if (sample) begin
          par_bit_q <= rx_s2_q;
          par_err_q <= rx_s2_q != (^shift_q ^ par_odd_q);
          state_q   <= S_STOP1;
        end
        S_STOP1: if (sample) begin
          if (!rx_s2_q) begin
            push_q     <= 1'b1;
            push_ent_q <= {brk_det, 1'b1, par_err_q, shift_q};
            state_q    <= brk_det ? S_WAIT_HI : S_IDLE;
          end else if (stop2_q) begin
            state_q <= S_STOP2;
          end else begin
            push_q     <= 1'b1;
            push_ent_q <= {2'b00, par_err_q, shift_q};
            state_q    <= S_IDLE;
          end
        end
        S_STOP2: if (sample) begin
          push_q     <= 1'b1;
          push_ent_q <= {1'b0, !rx_s2_q, par_err_q, shift_q};
          state_q    <= S_IDLE;
        end
        S_WAIT_HI: if (rx_s2_q) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] level_q, level_d;
  logic          overrun_q, thresh_q;
  logic          full, empty, rd_eff, wr_en;

  assign full   = (level_q == CW'(FIFO_DEPTH));
  assign empty  = (level_q == '0);
  assign rd_eff = rd_if.rden_i && !empty;
  // a pop in the same cycle makes room, so a push into a full FIFO still lands
  assign wr_en  = push_q && (!full || rd_eff);

  always_comb begin
    level_d = level_q;
    case ({wr_en, rd_eff})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_ent_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      thresh_q  <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (rd_eff) rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      level_q   <= level_d;
      // set wins over a simultaneous clear
      overrun_q <= (push_q && full && !rd_eff) || (overrun_q && !rd_if.ovr_clr_i);
      thresh_q  <= (cfg_thresh_i != '0) && (level_q >= cfg_thresh_i);
    end
  end

  // ---------------- receive timeout ----------------
  logic [TOW-1:0] to_cnt_q;
  logic           to_irq_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      to_cnt_q <= '0;
      to_irq_q <= 1'b0;
    end else begin
      if (push_q || rd_eff || start_det || empty)
        to_cnt_q <= '0;
      else if (baud_tick_i && (state_q == S_IDLE) && (to_cnt_q != TOW'(TO_TICKS)))
        to_cnt_q <= to_cnt_q + 1'b1;
      // a new start bit restarts the count but leaves a pending interrupt raised
      if (push_q || rd_eff || empty)
        to_irq_q <= 1'b0;
      else if (to_cnt_q == TOW'(TO_TICKS))
        to_irq_q <= 1'b1;
    end
  end

  // ---------------- outputs ----------------
  logic [EW-1:0] head;
  assign head = mem_q[rd_ptr_q];

  assign rd_if.rd_data_o     = empty ? '0 : head[DATA_WIDTH-1:0];
  assign rd_if.rd_err_o      = empty ? '0 : head[EW-1:DATA_WIDTH];
  assign rd_if.level_o       = level_q;
  assign rd_if.full_o        = full;
  assign rd_if.empty_o       = empty;
  assign rd_if.overrun_o     = overrun_q;
  assign rd_if.thresh_irq_o  = thresh_q;
  assign rd_if.timeout_irq_o = to_irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl (FIFO_DEPTH=4): constant vector table for framing/error tags,
// hand sequences for break, glitch, threshold, overrun, pop/push collision and timeout, then random frames
// checked against a queue-based reference model.
module tb_uart_rx_fifo_ctrl;
  localparam int DW = 8, DEPTH = 4, OS = 16, TOC = 4;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BIT_CYC = 2 * OS;               // baud tick every other clock
  localparam int TO_TICKS = TOC * 10 * OS;

  logic clk = 0, rstn = 0, baud_tick = 0, rx = 1;
  logic par_en = 0, par_odd = 0, stop2 = 0;
  logic [CW-1:0] thresh = '0;

  uart_rx_fifo_ctrl_if #(.DATA_WIDTH(DW), .CW(CW)) rif ();

  uart_rx_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS), .TIMEOUT_CHARS(TOC)) dut (
    .clk_i(clk), .rstn_i(rstn), .baud_tick_i(baud_tick), .rx_i(rx),
    .cfg_par_en_i(par_en), .cfg_par_odd_i(par_odd), .cfg_stop2_i(stop2),
    .cfg_thresh_i(thresh), .rd_if(rif)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); #1; baud_tick = ~baud_tick; end

  int n_chk = 0, n_fail = 0;
  logic [10:0] q[$];           // expected FIFO contents {err, data}
  bit model_ovr = 0;
  int pulse_d = -1;
  bit mon_en = 0, dip = 0;

  typedef struct {
    logic [7:0] d; bit pe, po, s2, pf; logic s1v, s2v;
    logic [7:0] ed; logic [2:0] ee;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // one bit time on the line; optional single-cycle pop at offset pulse_d within the last stop bit
  task automatic drive_bit(input logic v, input bit last);
    for (int c = 0; c < BIT_CYC; c++) begin
      @(posedge clk); #1;
      rx = v;
      rif.rden_i = last && (c == pulse_d);
      if (mon_en && rif.level_o != CW'(DEPTH)) dip = 1;
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (2 * n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe, po, s2, pf, input logic s1v, s2v);
    par_en = pe; par_odd = po; stop2 = s2;
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    {par_en, par_odd, stop2} = 3'($urandom);     // must not affect the frame in flight
    for (int i = 0; i < 8; i++) drive_bit(d[i], 0);
    if (pe) drive_bit((^d) ^ po ^ pf, 0);
    drive_bit(s1v, !s2);
    if (s2) drive_bit(s2v, 1);
    drive_bit(1'b1, 0);
  endtask

  function automatic logic [10:0] exp_ent(input logic [7:0] d, input bit pe, po, s2, pf, input logic s1v, s2v);
    logic perr, pbit, brk;
    perr = pe && pf;
    pbit = pe ? ((^d) ^ po ^ pf) : 1'b0;
    if (!s1v) begin
      brk = (d == 8'h00) && !pbit;
      return {brk, 1'b1, perr, d};
    end
    return {1'b0, s2 && !s2v, perr, d};
  endfunction

  function automatic void model_push(input logic [10:0] e);
    if (q.size() == DEPTH) model_ovr = 1;
    else q.push_back(e);
  endfunction

  task automatic pop_chk(input string nm);
    if (q.size() == 0) chk({nm, "_empty"}, rif.empty_o, 1);
    else begin
      chk({nm, "_data"}, rif.rd_data_o, q[0][7:0]);
      chk({nm, "_err"}, rif.rd_err_o, q[0][10:8]);
      void'(q.pop_front());
    end
    @(posedge clk); #1 rif.rden_i = 1;
    @(posedge clk); #1 rif.rden_i = 0;
  endtask

  task automatic clr_ovr();
    @(posedge clk); #1 rif.ovr_clr_i = 1;
    @(posedge clk); #1 rif.ovr_clr_i = 0;
    model_ovr = 0;
  endtask

  initial begin
    logic [7:0] tmp;
    bit found, prev_dip;
    tbl[0] = '{8'h55, 0, 0, 0, 0, 1, 1, 8'h55, 3'b000};
    tbl[1] = '{8'hA3, 1, 0, 0, 1, 1, 1, 8'hA3, 3'b001};
    tbl[2] = '{8'hA3, 1, 1, 0, 0, 1, 1, 8'hA3, 3'b000};
    tbl[3] = '{8'h3C, 0, 0, 1, 0, 1, 0, 8'h3C, 3'b010};
    tbl[4] = '{8'h81, 0, 0, 0, 0, 0, 1, 8'h81, 3'b010};
    tbl[5] = '{8'h00, 1, 1, 1, 0, 1, 1, 8'h00, 3'b000};
    tbl[6] = '{8'h00, 1, 1, 0, 0, 0, 1, 8'h00, 3'b010};
    tbl[7] = '{8'h00, 1, 0, 0, 0, 0, 1, 8'h00, 3'b110};
    rif.rden_i = 0; rif.ovr_clr_i = 0;

    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_empty", rif.empty_o, 1);
    chk("rst_level", rif.level_o, 0);
    chk("rst_full", rif.full_o, 0);
    chk("rst_data", rif.rd_data_o, 0);
    chk("rst_err", rif.rd_err_o, 0);
    chk("rst_ovr", rif.overrun_o, 0);
    chk("rst_thr", rif.thresh_irq_o, 0);
    chk("rst_to", rif.timeout_irq_o, 0);
    rstn = 1;
    drive_bit(1'b1, 0);

    // short low glitch is a false start
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1 rx = 0; end
    drive_bit(1'b1, 0); drive_bit(1'b1, 0);
    chk("glitch_empty", rif.empty_o, 1);

    // framing / error-tag vectors
    foreach (tbl[i]) begin
      send_frame(tbl[i].d, tbl[i].pe, tbl[i].po, tbl[i].s2, tbl[i].pf, tbl[i].s1v, tbl[i].s2v);
      chk($sformatf("vec%0d_level", i), rif.level_o, 1);
      chk($sformatf("vec%0d_data", i), rif.rd_data_o, tbl[i].ed);
      chk($sformatf("vec%0d_err", i), rif.rd_err_o, tbl[i].ee);
      @(posedge clk); #1 rif.rden_i = 1;
      @(posedge clk); #1 rif.rden_i = 0;
      chk($sformatf("vec%0d_popped", i), rif.empty_o, 1);
    end

    // line held low for two frame times: one break entry only
    drive_bit(1'b1, 0);
    for (int i = 0; i < 22; i++) drive_bit(1'b0, 0);
    chk("brk_level", rif.level_o, 1);
    chk("brk_data", rif.rd_data_o, 0);
    chk("brk_err", rif.rd_err_o, 3'b110);
    drive_bit(1'b1, 0); drive_bit(1'b1, 0);
    chk("brk_level_after", rif.level_o, 1);
    q.push_back({3'b110, 8'h00});
    pop_chk("brk_pop");

    // threshold interrupt
    thresh = 3;
    send_frame(8'h01, 0, 0, 0, 0, 1, 1); q.push_back({3'b0, 8'h01});
    send_frame(8'h02, 0, 0, 0, 0, 1, 1); q.push_back({3'b0, 8'h02});
    chk("thr_below", rif.thresh_irq_o, 0);
    send_frame(8'h03, 0, 0, 0, 0, 1, 1); q.push_back({3'b0, 8'h03});
    chk("thr_rise", rif.thresh_irq_o, 1);
    pop_chk("thr_pop");
    chk("thr_lag", rif.thresh_irq_o, 1);
    @(posedge clk); #1;
    chk("thr_fall", rif.thresh_irq_o, 0);
    while (q.size() > 0) pop_chk("thr_drain");
    thresh = 0;

    // five frames, no reads
    for (int i = 0; i < 5; i++) begin
      tmp = 8'((i + 1) * 17);
      send_frame(tmp, 0, 0, 0, 0, 1, 1);
      model_push({3'b0, tmp});
    end
    chk("ovr_level", rif.level_o, DEPTH);
    chk("ovr_full", rif.full_o, 1);
    chk("ovr_flag", rif.overrun_o, model_ovr);
    while (q.size() > 0) pop_chk("ovr_drain");
    chk("ovr_sticky", rif.overrun_o, 1);
    clr_ovr();
    chk("ovr_clr", rif.overrun_o, 0);

    // pop/push collision while full: sweep a one-cycle pop across the last stop bit
    for (int i = 0; i < DEPTH; i++) begin
      tmp = 8'(8'h60 + i);
      send_frame(tmp, 0, 0, 0, 0, 1, 1);
      q.push_back({3'b0, tmp});
    end
    found = 0; prev_dip = 1;
    for (int d = 6; d <= 30 && !found; d++) begin
      tmp = 8'(8'h70 + d);
      pulse_d = d; dip = 0; mon_en = 1;
      send_frame(tmp, 0, 0, 0, 0, 1, 1);
      mon_en = 0; pulse_d = -1;
      if (d == 6) chk("coll_early_dip", dip, 1);
      if (rif.overrun_o) begin
        found = 1;
        chk("coll_same_cycle_nodip", prev_dip, 0);
        chk("coll_late_level", rif.level_o, DEPTH - 1);
        void'(q.pop_front());
      end else begin
        chk("coll_level", rif.level_o, DEPTH);
        void'(q.pop_front());
        q.push_back({3'b0, tmp});
        prev_dip = dip;
      end
    end
    chk("coll_found", found, 1);
    while (q.size() > 0) pop_chk("coll_drain");
    clr_ovr();

    // receive timeout
    send_frame(8'hA1, 0, 0, 0, 0, 1, 1); q.push_back({3'b0, 8'hA1});
    send_frame(8'hA2, 0, 0, 0, 0, 1, 1); q.push_back({3'b0, 8'hA2});
    wait_ticks(TO_TICKS - 40);
    chk("to_early", rif.timeout_irq_o, 0);
    wait_ticks(40);
    chk("to_fire", rif.timeout_irq_o, 1);
    pop_chk("to_pop");
    chk("to_clr", rif.timeout_irq_o, 0);
    wait_ticks(100);
    chk("to_restart", rif.timeout_irq_o, 0);
    pop_chk("to_pop2");
    wait_ticks(TO_TICKS + 50);
    chk("to_empty", rif.timeout_irq_o, 0);

    // random frames vs reference model
    for (int it = 0; it < 30; it++) begin
      logic [7:0] d; bit pe, po, s2, pf; logic s1v, s2v; int np;
      d = 8'($urandom); pe = 1'($urandom); po = 1'($urandom); s2 = 1'($urandom);
      pf = ($urandom_range(3) == 0); s1v = ($urandom_range(7) != 0); s2v = ($urandom_range(7) != 0);
      send_frame(d, pe, po, s2, pf, s1v, s2v);
      model_push(exp_ent(d, pe, po, s2, pf, s1v, s2v));
      np = $urandom_range(2);
      for (int k = 0; k < np; k++) pop_chk($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_level", it), rif.level_o, q.size());
      chk($sformatf("rnd%0d_ovr", it), rif.overrun_o, model_ovr);
      if ($urandom_range(3) == 0) clr_ovr();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
